// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port synchronous data memory between two requesters:
//   port 0 (processor load/store) and port 1 (program loader / debug master).
//   At most one access is issued per clock. Ties are broken round-robin.
//   Port 1 may lock the memory for bursts. While port 0 waits, port 1 gets at
//   most MAX_LOCK consecutive locked grants before port 0 is given one slot.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   pX_req/wren/addr/wdata  request from port X, held until pX_gnt
//   pX_gnt                  access for port X is issued this cycle
//   pX_rvalid/rdata         read return, one cycle after a read grant
//   p1_lock                 port 1 asks for back-to-back ownership
//   mem_addr/wren/wdata     dmem command (all zero when nothing is granted)
//   mem_rdata               dmem read data, valid one cycle after the address
//   busy                    a grant or a read return is active this cycle
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_wren,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_wren,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic                  p1_lock,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wren,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, LOCK1 = 1'b1} state_t;

  localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

  state_t     state;
  logic       last_gnt;     // 0: port 0 granted last, 1: port 1 granted last
  logic [7:0] lock_cnt;     // locked port-1 grants while port 0 waits
  logic       rd_vld_p1;    // a read was issued in the previous cycle
  logic       rd_port_p1;   // port that issued it (1 = port 1)

  logic lock_hold;
  logic starve;
  logic gnt0;
  logic gnt1;

  // Arbitration: combinational from the current requests and registered state.
  always_comb begin
    lock_hold = (state == LOCK1) && p1_req && p1_lock;
    starve    = lock_hold && p0_req && (lock_cnt == LOCK_LIMIT);
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (lock_hold) begin
      gnt0 = starve;
      gnt1 = !starve;
    end else if (p0_req && p1_req) begin
      // Grant the port opposite the last winner.
      gnt0 = last_gnt;
      gnt1 = !last_gnt;
    end else begin
      gnt0 = p0_req;
      gnt1 = p1_req;
    end
  end

  // Reset masks the grants so the memory command drops as soon as reset asserts.
  assign p0_gnt = gnt0 && reset;
  assign p1_gnt = gnt1 && reset;

  always_comb begin
    mem_addr  = '0;
    mem_wren  = 1'b0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_addr  = p0_addr;
      mem_wren  = p0_wren;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_addr  = p1_addr;
      mem_wren  = p1_wren;
      mem_wdata = p1_wdata;
    end
  end

  // Registered arbitration state and read-return tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      lock_cnt   <= '0;
      rd_vld_p1  <= 1'b0;
      rd_port_p1 <= 1'b0;
    end else begin
      if (p0_gnt) begin
        last_gnt <= 1'b0;
      end else if (p1_gnt) begin
        last_gnt <= 1'b1;
      end

      // A forced port-0 slot keeps the lock; any other cycle re-decides it.
      state <= ((p1_gnt && p1_lock) || starve) ? LOCK1 : IDLE;

      // Every locked port-1 grant taken while port 0 waits counts, including
      // the grant that enters the lock.
      if (p0_gnt || !p0_req) begin
        lock_cnt <= '0;
      end else if (p1_gnt && p1_lock && (lock_cnt != LOCK_LIMIT)) begin
        lock_cnt <= lock_cnt + 8'd1;
      end

      rd_vld_p1  <= (p0_gnt && !p0_wren) || (p1_gnt && !p1_wren);
      rd_port_p1 <= p1_gnt;
    end
  end

  // Return stage: memory data arrives one cycle after the granted address.
  assign p0_rvalid = rd_vld_p1 && !rd_port_p1;
  assign p1_rvalid = rd_vld_p1 && rd_port_p1;
  assign p0_rdata  = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : '0;

  assign busy = p0_gnt || p1_gnt || p0_rvalid || p1_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// scoreboarded against a cycle-level reference model of the arbitration rules
// and a reference copy of the memory contents.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int ML = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          p0_req = 1'b0, p0_wren = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_wren = 1'b0, p1_lock = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_wren, busy;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_wren(p0_wren), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wren(p1_wren), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 'h010) return 32'hDEADBEEF;
    return (i * 32'h9E3779B9) ^ 32'h00C0FFEE;
  endfunction

  // Synchronous single-port memory driven by the DUT's memory command.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit            ram_ready = 1'b0;
  always @(posedge clock) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    bit            g0, g1, wren, rv0, rv1;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rd0, rd1;
  } exp_t;
  exp_t gq[$];

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            m_last;      // port that won the most recent grant
  bit            m_locked;    // port 1 currently owns the lock
  int            m_run;       // locked port-1 grants since port 0 last got in
  bit            m_pv, m_pport;
  logic [DW-1:0] m_pdata;
  bit            m_g0, m_g1;
  bit            mon_en = 1'b0;

  task automatic model_reset();
    m_last = 1; m_locked = 0; m_run = 0; m_pv = 0; m_pport = 0; m_pdata = '0;
  endtask

  task automatic set0(bit r, bit w, int a, logic [DW-1:0] d);
    p0_req = r; p0_wren = w; p0_addr = a[AW-1:0]; p0_wdata = d;
  endtask

  task automatic set1(bit r, bit w, int a, logic [DW-1:0] d, bit l);
    p1_req = r; p1_wren = w; p1_addr = a[AW-1:0]; p1_wdata = d; p1_lock = l;
  endtask

  // Decide this cycle's expected behaviour from the rules, queue it, advance
  // the model, and move to 1 time unit after the next rising edge.
  task automatic step();
    exp_t e;
    bit   hold;
    hold = m_locked && p1_req && p1_lock;
    m_g0 = 0; m_g1 = 0;
    if (hold) begin
      if (p0_req && m_run >= ML) m_g0 = 1; else m_g1 = 1;
    end else if (p0_req && p1_req) begin
      if (m_last == 1) m_g0 = 1; else m_g1 = 1;
    end else begin
      m_g0 = p0_req; m_g1 = p1_req;
    end
    e.g0 = m_g0; e.g1 = m_g1;
    e.addr  = m_g0 ? p0_addr  : (m_g1 ? p1_addr  : '0);
    e.wren  = m_g0 ? p0_wren  : (m_g1 ? p1_wren  : 1'b0);
    e.wdata = m_g0 ? p0_wdata : (m_g1 ? p1_wdata : '0);
    e.rv0 = m_pv && !m_pport;
    e.rv1 = m_pv && m_pport;
    e.rd0 = e.rv0 ? m_pdata : '0;
    e.rd1 = e.rv1 ? m_pdata : '0;
    gq.push_back(e);
    m_pv    = (m_g0 && !p0_wren) || (m_g1 && !p1_wren);
    m_pport = m_g1;
    if (m_pv) m_pdata = ref_mem[e.addr];
    if (e.wren) ref_mem[e.addr] = e.wdata;
    if (m_g0) m_last = 0; else if (m_g1) m_last = 1;
    m_locked = (m_g1 && p1_lock) || (hold && m_g0);
    if (m_g0 || !p0_req) m_run = 0;
    else if (m_g1 && p1_lock) m_run++;
    @(posedge clock); #1;
  endtask

  exp_t me;
  always @(negedge clock) begin
    if (mon_en && reset) begin
      if (gq.size() == 0) begin
        chk("sb_queue_empty", 0, 1);
      end else begin
        me = gq.pop_front();
        chk("p0_gnt", p0_gnt, me.g0);
        chk("p1_gnt", p1_gnt, me.g1);
        chk("mem_addr", mem_addr, me.addr);
        chk("mem_wren", mem_wren, me.wren);
        chk("mem_wdata", mem_wdata, me.wdata);
        chk("p0_rvalid", p0_rvalid, me.rv0);
        chk("p1_rvalid", p1_rvalid, me.rv1);
        chk("p0_rdata", p0_rdata, me.rd0);
        chk("p1_rdata", p1_rdata, me.rd1);
        chk("busy", busy, me.g0 | me.g1 | me.rv0 | me.rv1);
      end
    end
  end

  int n_p1, first_p0, n_p0, a1, a0;
  int pr0, pr1, plk;

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);
    model_reset();

    // Reset state: requests present but nothing may be granted.
    set0(1, 1, 'h005, 32'h1111_1111);
    set1(1, 1, 'h006, 32'h2222_2222, 1);
    #2;
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    @(posedge clock); #1;
    chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
    @(posedge clock); #1;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    reset = 1'b1;
    mon_en = 1'b1;

    // T1: lone p0 read of 0x010.
    set0(1, 0, 'h010, 0);
    step();
    set0(0, 0, 0, 0);
    step();
    step();

    // T2: both ports write continuously; grants alternate.
    a0 = 'h040; a1 = 'h080;
    set0(1, 1, a0, 32'hA000_0000);
    set1(1, 1, a1, 32'hB000_0000, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      if (m_g0) begin a0++; set0(1, 1, a0, 32'hA000_0000 + a0); end
      if (m_g1) begin a1++; set1(1, 1, a1, 32'hB000_0000 + a1, 0); end
    end
    set0(0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    step();

    // T3: p1 locked burst reads from 0x100 with p0 waiting.
    set0(1, 0, 'h1F0, 0);
    step();                                   // p0 alone: it becomes last winner
    a0 = 'h200; a1 = 'h100;
    set0(1, 0, a0, 0);
    set1(1, 0, a1, 0, 1);
    n_p1 = 0; n_p0 = 0; first_p0 = -1;
    for (int k = 0; k < 17; k++) begin
      step();
      if (m_g0) begin
        n_p0++;
        if (first_p0 < 0) first_p0 = k;
        a0++; set0(1, 0, a0, 0);
      end
      if (m_g1) begin
        n_p1++;
        a1 = (a1 == 'h10F) ? 'h100 : a1 + 1;
        set1(1, 0, a1, 0, 1);
      end
    end
    chk("t3_p1_before_p0", first_p0, 8);
    chk("t3_p0_slots", n_p0, 1);
    chk("t3_p1_total", n_p1, 16);

    // T4: p0 idle, p1 locked for 20 cycles.
    set0(0, 0, 0, 0);
    n_p1 = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (m_g1) begin n_p1++; a1++; set1(1, 0, a1, 0, 1); end
    end
    chk("t4_p1_grants", n_p1, 20);
    set1(0, 0, 0, 0, 0);
    step();

    // T5: asynchronous reset right after a p0 read grant.
    mon_en = 1'b0;
    set0(1, 0, 'h030, 0);
    #1;
    chk("t5_gnt_pre", p0_gnt, 1);
    chk("t5_addr_pre", mem_addr, 'h030);
    #1 reset = 1'b0;
    #1;
    chk("t5_gnt_rst", p0_gnt, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_addr_rst", mem_addr, 0);
    chk("t5_wren_rst", mem_wren, 0);
    @(posedge clock); #1;
    chk("t5_rvalid_rst", p0_rvalid, 0);
    model_reset();
    set1(1, 1, 'h031, 32'h0000_00AB, 0);
    reset = 1'b1;
    #1;
    chk("t5_first_p0", {p0_gnt, p1_gnt}, 2'b10);
    mon_en = 1'b1;
    step();
    set0(0, 0, 0, 0);
    step();
    set1(0, 0, 0, 0, 0);
    step();

    // T6: p0 writes 0x55 to 0x020, p1 reads it back the next cycle.
    set0(1, 1, 'h020, 32'h0000_0055);
    step();
    set0(0, 0, 0, 0);
    set1(1, 0, 'h020, 0, 0);
    step();
    set1(0, 0, 0, 0, 0);
    step();

    // Randomized traffic in three mixes.
    for (int ph = 0; ph < 3; ph++) begin
      pr0 = (ph == 0) ? 50 : (ph == 1) ? 90 : 30;
      pr1 = (ph == 0) ? 50 : 95;
      plk = (ph == 0) ? 0  : (ph == 1) ? 70 : 90;
      for (int c = 0; c < 150; c++) begin
        step();
        if (m_g0 || !p0_req) begin
          if ($urandom_range(99) < pr0)
            set0(1, 1'($urandom_range(1)), $urandom_range(63), $urandom);
          else
            set0(0, 0, 0, 0);
        end
        if (m_g1 || !p1_req) begin
          if ($urandom_range(99) < pr1)
            set1(1, 1'($urandom_range(1)), $urandom_range(63), $urandom,
                 $urandom_range(99) < plk);
          else
            set1(0, 0, 0, 0, 0);
        end
      end
    end
    set0(0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    step();
    step();

    for (int k = 0; k < 5 && gq.size() != 0; k++) @(posedge clock);
    if (gq.size() != 0) chk("sb_drain", gq.size(), 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory (dmem) between two requesters.
- Port 0 is the processor load/store path; port 1 is a program-loader/debug master.
- Issues at most one access per clock, using round-robin arbitration with an optional port-1 lock for bursts.
- Bounded starvation for port 0 while port 1 is locked.
- Sits between the processor core and dmem in the skeleton top level.

Parameters:
- ADDR_WIDTH, 12, dmem word-address width.
- DATA_WIDTH, 32, data word width.
- MAX_LOCK, 8, max consecutive port-1 locked grants while port 0 waits (range 1..255).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 access request; held with its signals until p0_gnt.
- p0_wren  in  1  port 0 write enable (1=write, 0=read).
- p0_addr  in  ADDR_WIDTH  port 0 address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_gnt  out  1  port 0 access issued this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DATA_WIDTH  port 0 read data.
- p1_req, p1_wren, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: as port 0, for port 1.
- p1_lock  in  1  port 1 requests back-to-back ownership.
- mem_addr  out  ADDR_WIDTH  dmem address.
- mem_wren  out  1  dmem write enable.
- mem_wdata  out  DATA_WIDTH  dmem write data.
- mem_rdata  in  DATA_WIDTH  dmem read data; valid one cycle after address.
- busy  out  1  a grant or a read return is active this cycle.

Behaviour:
- Reset (reset=0, async): all grant and rvalid outputs, busy and mem_wren go 0, and mem_addr/mem_wdata go 0.
  - last_gnt=1, so port 0 wins the first tie.
  - The lock counter clears and state goes to IDLE.
  - A read in flight is discarded: no rvalid after reset.
- Grant logic (combinational from current req and registered state):
  - Exactly one of p0_gnt/p1_gnt is high, or neither.
  - While a grant is high, mem_addr/mem_wren/mem_wdata equal the granted port's signals.
  - With no grant, mem_wren=0 and mem_addr=mem_wdata=0.
- Handshake: an access completes in the cycle gnt=1. A requester may change its signals or drop req only after a gnt edge. Back-to-back grants to the same port are allowed.
- Read return: a read granted in cycle N gives px_rvalid=1 in cycle N+1 only, with px_rdata=mem_rdata. px_rdata=0 when rvalid=0. A write never produces rvalid.
- State machine (registered):
  - IDLE: one requester -> grant it. Both -> grant the port opposite last_gnt. Move to LOCK1 if p1 is granted with p1_lock=1.
  - LOCK1: p1_req&p1_lock -> grant p1, unless the starvation rule fires.
  - LOCK1 exits: p1_lock=0 or p1_req=0 -> behave as IDLE this cycle and return to IDLE.
  - Starvation: in LOCK1, cnt increments each cycle p1 is granted while p0_req=1. cnt==MAX_LOCK with p0_req=1 -> grant p0 for one cycle, clear cnt, stay in LOCK1.
  - cnt clears whenever p0 is granted or p0_req=0.
- last_gnt updates to the granted port on every grant and holds otherwise.
- busy = p0_gnt | p1_gnt | p0_rvalid | p1_rvalid.
- Simultaneous grant in N and return in N+1: legal every cycle, giving full throughput of one access per cycle.

Test Plan:
1. Reset then p0 read addr 0x010 alone, mem holds 0xDEADBEEF -> p0_gnt in the same cycle, mem_addr=0x010, next cycle p0_rvalid=1 and p0_rdata=0xDEADBEEF, p1 outputs 0.
2. p0 and p1 both request writes continuously after reset -> grants alternate p0,p1,p0,p1. mem_wdata tracks the granted port. No rvalid.
3. p1_lock=1 with p1 reads to 0x100..0x10F, p0_req held, MAX_LOCK=8 -> 8 p1 grants, 1 p0 grant, then 8 p1 grants. p1_rvalid follows each p1 grant by one cycle with the matching data.
4. p1 locked, p0 idle for 20 cycles -> 20 consecutive p1 grants with no forced p0 slot. cnt stays 0.
5. reset asserted asynchronously mid-cycle right after a p0 read grant -> all outputs 0 immediately, no p0_rvalid the next cycle. After release with both requesting, p0 wins first.
6. Alternating write 0x55 to 0x020 by p0 then read 0x020 by p1 in the next cycle -> p1_rdata=0x00000055 one cycle after p1_gnt.
